// File: rtl/traffic_phase_sched_pkg.sv
// Shared types and constants for the intersection phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GRN,
    A_YEL,
    ALL_RED2,
    B_GRN,
    B_YEL,
    ALL_RED1,
    FLASH
  } phase_e;

  // light1 bit positions: road A in [5:3], road B in [2:0], each {R,Y,G}
  localparam int unsigned LT_A_R = 5;
  localparam int unsigned LT_A_Y = 4;
  localparam int unsigned LT_A_G = 3;
  localparam int unsigned LT_B_R = 2;
  localparam int unsigned LT_B_Y = 1;
  localparam int unsigned LT_B_G = 0;

  localparam logic [5:0] LT_A_GRN   = 6'b001_100;
  localparam logic [5:0] LT_A_YEL   = 6'b010_100;
  localparam logic [5:0] LT_B_GRN   = 6'b100_001;
  localparam logic [5:0] LT_B_YEL   = 6'b100_010;
  localparam logic [5:0] LT_ALL_RED = 6'b100_100;
  localparam logic [5:0] LT_FLASH   = 6'b010_010;
  localparam logic [5:0] LT_OFF     = 6'b000_000;

  // Steady light pattern for a phase; FLASH is toggled by the scheduler itself.
  function automatic logic [5:0] light_of(input phase_e p);
    case (p)
      A_GRN:   return LT_A_GRN;
      A_YEL:   return LT_A_YEL;
      B_GRN:   return LT_B_GRN;
      B_YEL:   return LT_B_YEL;
      FLASH:   return LT_FLASH;
      default: return LT_ALL_RED;
    endcase
  endfunction

  // Two-digit BCD of 0..99 by repeated compare/subtract of ten.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] t;
    r = v;
    t = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    return {t, 4'(r)};
  endfunction

endpackage

// File: rtl/traffic_phase_sched_if.sv
// Control inputs and display/light outputs of the phase scheduler.
interface traffic_phase_sched_if;
  logic       ped_req;
  logic       emg_hold;
  logic       night;
  logic [5:0] light1;
  logic [3:0] time_tens;
  logic [3:0] time_ones;
  logic       phase_done;

  modport master (
    output ped_req, emg_hold, night,
    input  light1, time_tens, time_ones, phase_done
  );

  modport slave (
    input  ped_req, emg_hold, night,
    output light1, time_tens, time_ones, phase_done
  );
endinterface

// File: rtl/traffic_phase_sched_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  // Count up to TICK_DIV-1, then wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road phase scheduler: phase FSM, countdown, pedestrian latch, BCD display.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned GREEN_T  = 25,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned PED_T    = 5
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  traffic_phase_sched_if.slave  bus
);
  localparam logic [6:0] GRN_R = 7'(GREEN_T);
  localparam logic [6:0] YEL_R = 7'(YELLOW_T);
  localparam logic [6:0] RED_R = 7'(ALLRED_T);
  localparam logic [6:0] PED_R = 7'(PED_T);
  localparam logic [7:0] BCD_RST = to_bcd(RED_R);

  logic       tick;
  phase_e     state_q, state_d;
  logic [6:0] remain_q, remain_d;
  logic       ped_q, ped_d;
  logic [5:0] light_q, light_d;
  logic [7:0] bcd_q, bcd_d;
  logic       done_q, done_d;
  logic       expire;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk_50m),
    .rst_i  (rst),
    .tick_o (tick)
  );

  assign expire = tick && (remain_q == 7'd1);

  // Next phase/countdown; priority emg_hold > night > tick expiry > ped_req.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    ped_d    = ped_q | bus.ped_req;
    case (state_q)
      A_GRN, B_GRN: begin
        // any pending request is consumed here; a new pulse re-arms the latch
        ped_d = bus.ped_req;
        if (bus.emg_hold || expire) begin
          state_d  = (state_q == A_GRN) ? A_YEL : B_YEL;
          remain_d = YEL_R;
        end else begin
          remain_d = tick ? remain_q - 7'd1 : remain_q;
          if (ped_q && remain_d > PED_R) remain_d = PED_R;
        end
      end
      A_YEL, B_YEL: begin
        if (expire) begin
          state_d  = (state_q == A_YEL) ? ALL_RED2 : ALL_RED1;
          remain_d = RED_R;
        end else if (tick) begin
          remain_d = remain_q - 7'd1;
        end
      end
      ALL_RED1, ALL_RED2: begin
        if (bus.emg_hold) begin
          remain_d = remain_q;
        end else if (expire) begin
          if (bus.night) begin
            state_d = FLASH;
          end else begin
            state_d  = (state_q == ALL_RED2) ? B_GRN : A_GRN;
            remain_d = GRN_R;
          end
        end else if (tick) begin
          remain_d = remain_q - 7'd1;
        end
      end
      FLASH: begin
        ped_d = 1'b0;
        if (bus.emg_hold || !bus.night) begin
          state_d  = ALL_RED1;
          remain_d = RED_R;
        end
      end
      default: begin
        state_d  = ALL_RED1;
        remain_d = RED_R;
      end
    endcase

    // FLASH starts lit and toggles per tick; other phases use their fixed pattern
    if (state_d == FLASH) begin
      if (state_q != FLASH) light_d = LT_FLASH;
      else if (tick) light_d = (light_q == LT_FLASH) ? LT_OFF : LT_FLASH;
      else light_d = light_q;
    end else begin
      light_d = light_of(state_d);
    end

    bcd_d  = (state_d == FLASH) ? 8'h00 : to_bcd(remain_d);
    done_d = (state_d != state_q);
  end

  // Register state and all outputs together.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q  <= ALL_RED1;
      remain_q <= RED_R;
      ped_q    <= 1'b0;
      light_q  <= LT_ALL_RED;
      bcd_q    <= BCD_RST;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      ped_q    <= ped_d;
      light_q  <= light_d;
      bcd_q    <= bcd_d;
      done_q   <= done_d;
    end
  end

  assign bus.light1     = light_q;
  assign bus.time_tens  = bcd_q[7:4];
  assign bus.time_ones  = bcd_q[3:0];
  assign bus.phase_done = done_q;
endmodule

// File: tb/tb_traffic_phase_sched.sv
// Tick-aligned vector table plus hand sequences for edge-level corner cases.
module tb_traffic_phase_sched;
  localparam logic [5:0] AG  = 6'b001_100;
  localparam logic [5:0] AY  = 6'b010_100;
  localparam logic [5:0] BG  = 6'b100_001;
  localparam logic [5:0] BY  = 6'b100_010;
  localparam logic [5:0] AR  = 6'b100_100;
  localparam logic [5:0] FL  = 6'b010_010;
  localparam logic [5:0] OFF = 6'b000_000;

  typedef struct {
    logic [5:0] light;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       done;
  } exp_t;

  typedef struct {
    logic ped;
    logic emg;
    logic night;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  vec_t tbl[$];
  exp_t sb_q[$];

  traffic_phase_sched_if bus_if ();

  traffic_phase_sched #(
    .TICK_DIV(4), .GREEN_T(6), .YELLOW_T(2), .ALLRED_T(1), .PED_T(2)
  ) dut (
    .clk_50m (clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [5:0] l, input logic [3:0] t, input logic [3:0] o,
                              input logic d);
    exp_t e;
    e.light = l; e.tens = t; e.ones = o; e.done = d;
    return e;
  endfunction

  task automatic add(input logic p, input logic em, input logic n, input logic [5:0] l,
                     input logic [3:0] t, input logic [3:0] o, input logic d);
    vec_t v;
    v.ped = p; v.emg = em; v.night = n; v.e = mk(l, t, o, d);
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input exp_t e);
    tests++;
    if (bus_if.light1 !== e.light || bus_if.time_tens !== e.tens ||
        bus_if.time_ones !== e.ones || bus_if.phase_done !== e.done) begin
      failed++;
      $display("FAIL %s: got light1=%b bcd=%h%h done=%b, want light1=%b bcd=%h%h done=%b",
               nm, bus_if.light1, bus_if.time_tens, bus_if.time_ones, bus_if.phase_done,
               e.light, e.tens, e.ones, e.done);
    end
  endtask

  // One tick period: levels applied now, ped pulsed for the first cycle only.
  task automatic step(input string nm, input logic p, input logic em, input logic n, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    bus_if.emg_hold = em;
    bus_if.night    = n;
    bus_if.ped_req  = p;
    @(posedge clk); #1;
    bus_if.ped_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check(nm, got);
  endtask

  initial begin
    bit found;
    bus_if.ped_req  = 1'b0;
    bus_if.emg_hold = 1'b0;
    bus_if.night    = 1'b0;

    // normal cycle with pedestrian shortening
    add(0,0,0, AG,0,6,1); add(0,0,0, AG,0,5,0); add(1,0,0, AG,0,1,0);
    add(0,0,0, AY,0,2,1); add(0,0,0, AY,0,1,0); add(0,0,0, AR,0,1,1);
    add(0,0,0, BG,0,6,1); add(0,0,0, BG,0,5,0); add(0,0,0, BG,0,4,0);
    add(0,0,0, BG,0,3,0); add(0,0,0, BG,0,2,0); add(1,0,0, BG,0,1,0);
    add(0,0,0, BY,0,2,1); add(0,0,0, BY,0,1,0); add(0,0,0, AR,0,1,1);
    add(0,0,0, AG,0,6,1); add(0,0,0, AG,0,5,0);
    // emergency during green, yellow finishes, all-red frozen, release
    add(0,1,0, AY,0,1,0); add(0,1,0, AR,0,1,1); add(0,1,0, AR,0,1,0);
    add(0,1,0, AR,0,1,0); add(0,0,0, BG,0,6,1);
    // night: finish B green/yellow, then flash, ped cleared in flash
    add(0,0,1, BG,0,5,0); add(0,0,1, BG,0,4,0); add(0,0,1, BG,0,3,0);
    add(0,0,1, BG,0,2,0); add(0,0,1, BG,0,1,0); add(0,0,1, BY,0,2,1);
    add(0,0,1, BY,0,1,0); add(0,0,1, AR,0,1,1); add(0,0,1, FL,0,0,1);
    add(0,0,1, OFF,0,0,0); add(1,0,1, FL,0,0,0); add(0,0,0, AG,0,6,1);
    add(0,0,0, AG,0,5,0);
    // emg + night + expiry coincide at end of ALL_RED2
    add(0,0,0, AG,0,4,0); add(0,0,0, AG,0,3,0); add(0,0,0, AG,0,2,0);
    add(0,0,0, AG,0,1,0); add(0,0,0, AY,0,2,1); add(0,0,0, AY,0,1,0);
    add(0,0,0, AR,0,1,1); add(0,1,1, AR,0,1,0); add(0,0,1, FL,0,0,1);
    add(0,1,1, AR,0,1,0); add(0,0,0, AG,0,6,1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_values", mk(AR, 0, 1, 0));
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].ped, tbl[i].emg, tbl[i].night, tbl[i].e);

    // emergency in green acts on the very next edge; phase_done is one cycle
    bus_if.emg_hold = 1'b1;
    @(posedge clk); #1;
    check("emg_next_edge", mk(AY, 0, 2, 1));
    bus_if.emg_hold = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", mk(AY, 0, 2, 0));

    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (bus_if.light1 == BY) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL wait_b_yel: got light1=%b, want %b within 200 cycles", bus_if.light1, BY);
    end

    // asynchronous reset in the middle of B_YEL
    #2 rst = 1'b1;
    #1;
    check("async_reset", mk(AR, 0, 1, 0));
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("restart_a_grn", mk(AG, 0, 6, 1));

    // ped pulse on the phase-change edge is held until the next green
    step("pre5", 0,0,0, mk(AG,0,5,0));
    step("pre4", 0,0,0, mk(AG,0,4,0));
    step("pre3", 0,0,0, mk(AG,0,3,0));
    step("pre2", 0,0,0, mk(AG,0,2,0));
    step("pre1", 0,0,0, mk(AG,0,1,0));
    repeat (3) @(posedge clk);
    #1;
    bus_if.ped_req = 1'b1;
    @(posedge clk); #1;
    bus_if.ped_req = 1'b0;
    check("ped_at_change", mk(AY, 0, 2, 1));
    step("held_y1", 0,0,0, mk(AY,0,1,0));
    step("held_red", 0,0,0, mk(AR,0,1,1));
    step("held_bg", 0,0,0, mk(BG,0,6,1));
    @(posedge clk); #1;
    check("held_consumed", mk(BG, 0, 2, 0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end
endmodule
